// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: multiplexed common-cathode seven-segment scanner.
// Latches NDIG packed BCD digits plus decimal points on load, then walks one
// digit enable at a time, advancing every SCAN_DIV clk cycles. All display
// outputs are registered and change only on a scan tick.
// Optional feature macro: BCD_SEG_SCAN_LZB_EN enables leading-zero blanking.
module bcd_seg_scan #(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [4*NDIG-1:0]    bcd_in,
  input  logic [NDIG-1:0]      dp_in,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [NDIG-1:0]      an,
  output logic                 frame
);

  // SCAN_DIV = 1 would give a zero-width counter, so keep at least one bit.
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_MAX = IW'(NDIG - 1);

  logic [CW-1:0]     cnt;
  logic              tick;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     idx_nxt;
  logic [4*NDIG-1:0] sh_bcd;
  logic [NDIG-1:0]   sh_dp;
  logic [NDIG-1:0]   blank;
  logic [3:0]        dig_sel;
  logic [6:0]        seg_nxt;
  logic [NDIG-1:0]   an_nxt;
`ifdef BCD_SEG_SCAN_LZB_EN
  logic              nz_above;
`endif

  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // dash for codes 10..15
    endcase
    return s;
  endfunction

  assign tick = (cnt == CNT_MAX);

  // Prescaler: free-running 0..SCAN_DIV-1, tick on the last count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  // Shadow register, written only on load; outputs sample the old value on a
  // coincident tick because both update at the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_bcd <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_bcd <= bcd_in;
      sh_dp  <= dp_in;
    end
  end

  // Blank mask: digit i >= 1 dark when it and every higher digit read zero.
  always_comb begin
    blank = '0;
`ifdef BCD_SEG_SCAN_LZB_EN
    nz_above = 1'b0;
    for (int i = NDIG - 1; i >= 1; i--) begin
      nz_above = nz_above | (sh_bcd[4*i +: 4] != 4'd0);
      blank[i] = ~nz_above;
    end
`endif
  end

  // Next digit index and the output pattern it will show.
  always_comb begin
    idx_nxt = (idx == IDX_MAX) ? '0 : idx + 1'b1;
    dig_sel = sh_bcd[{idx_nxt, 2'b00} +: 4];
    seg_nxt = blank[idx_nxt] ? 7'h00 : bcd_to_seg(dig_sel);
    an_nxt  = '0;
    an_nxt[idx_nxt] = 1'b1;
  end

  // Scan index and registered display outputs, updated only on a tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      seg   <= 7'h3F;
      dp    <= 1'b0;
      an    <= NDIG'(1);
      frame <= 1'b0;
    end else if (tick) begin
      idx   <= idx_nxt;
      seg   <= seg_nxt;
      dp    <= sh_dp[idx_nxt];
      an    <= an_nxt;
      frame <= (idx == IDX_MAX);
    end else begin
      frame <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed self-checking bench for bcd_seg_scan (NDIG=4/SCAN_DIV=4 main
// instance plus an NDIG=2/SCAN_DIV=1 instance). Expectations follow
// BCD_SEG_SCAN_LZB_EN so the same bench covers both builds.
module tb_bcd_seg_scan;

`ifdef BCD_SEG_SCAN_LZB_EN
  localparam logic [6:0] ZB = 7'h00;
`else
  localparam logic [6:0] ZB = 7'h3F;
`endif

  logic        clk, rst, load;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  logic        load2;
  logic [7:0]  bcd2;
  logic [1:0]  dp2;
  logic [6:0]  seg2;
  logic        dpo2;
  logic [1:0]  an2;
  logic        frame2;

  int checks;
  int errors;
  int cur;

  bcd_seg_scan #(.NDIG(4), .SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .bcd_in(bcd_in), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  bcd_seg_scan #(.NDIG(2), .SCAN_DIV(1)) dut2 (
    .clk(clk), .rst(rst), .load(load2), .bcd_in(bcd2), .dp_in(dp2),
    .seg(seg2), .dp(dpo2), .an(an2), .frame(frame2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_tick();
    repeat (4) @(posedge clk);
    #1;
    cur = (cur + 1) % 4;
  endtask

  task automatic load_word(input logic [15:0] b, input logic [3:0] d);
    bcd_in = b;
    dp_in  = d;
    load   = 1'b1;
    @(posedge clk);
    #1;
    load = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cur = (cur + 1) % 4;
  endtask

  task automatic scan_frame(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3, input logic [3:0] edp);
    logic [6:0] e [4];
    logic [3:0] ean;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    while (cur != 3) next_tick();
    for (int d = 0; d < 4; d++) begin
      next_tick();
      ean = 4'b0001 << d;
      chk($sformatf("%s_an%0d", tag, d), an, ean);
      chk($sformatf("%s_seg%0d", tag, d), seg, e[d]);
      chk($sformatf("%s_dp%0d", tag, d), dp, edp[d]);
      chk($sformatf("%s_frame%0d", tag, d), frame, (d == 0));
    end
  endtask

  initial begin
    logic [3:0] ean;
    int d;
    clk = 0; rst = 0; load = 0; bcd_in = '0; dp_in = '0;
    load2 = 0; bcd2 = '0; dp2 = '0;
    checks = 0; errors = 0; cur = 0;

    // reset asserted between clock edges acts at once
    #7 rst = 1'b1;
    #1;
    chk("rst_an", an, 4'b0001);
    chk("rst_seg", seg, 7'h3F);
    chk("rst_dp", dp, 1'b0);
    chk("rst_frame", frame, 1'b0);
    chk("rst_an2", an2, 2'b01);
    chk("rst_frame2", frame2, 1'b0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // first ticks after release; dut2 rotates every cycle
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk);
      #1;
      d = (e / 4) % 4;
      ean = 4'b0001 << d;
      chk($sformatf("boot_an_e%0d", e), an, ean);
      chk($sformatf("boot_frame_e%0d", e), frame, (e == 16));
      chk($sformatf("boot_seg_e%0d", e), seg, (d == 0) ? 7'h3F : ZB);
      chk($sformatf("boot_an2_e%0d", e), an2, (e % 2 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("boot_frame2_e%0d", e), frame2, (e % 2 == 0));
      chk($sformatf("boot_seg2_e%0d", e), seg2, (e % 2 == 1) ? ZB : 7'h3F);
    end
    cur = 1;

    load_word(16'h9876, 4'b0000);
    scan_frame("d9876", 7'h7D, 7'h07, 7'h7F, 7'h6F, 4'b0000);
    load_word(16'h5432, 4'b0000);
    scan_frame("d5432", 7'h5B, 7'h4F, 7'h66, 7'h6D, 4'b0000);
    load_word(16'h0010, 4'b0000);
    scan_frame("d0010", 7'h3F, 7'h06, ZB, ZB, 4'b0000);
    load_word(16'hFA00, 4'b0101);
    scan_frame("dFA00", 7'h3F, 7'h3F, 7'h40, 7'h40, 4'b0101);
    load_word(16'h0070, 4'b0000);
    scan_frame("d0070", 7'h3F, 7'h07, ZB, ZB, 4'b0000);
    load_word(16'h0000, 4'b0000);
    scan_frame("d0000", 7'h3F, ZB, ZB, ZB, 4'b0000);

    // load held for three cycles: last capture wins
    dp_in = 4'b0000;
    load = 1'b1; bcd_in = 16'h1234;
    @(posedge clk); #1 bcd_in = 16'h8888;
    @(posedge clk); #1 bcd_in = 16'h0303;
    @(posedge clk); #1 load = 1'b0;
    @(posedge clk); #1;
    cur = (cur + 1) % 4;
    scan_frame("hold", 7'h4F, 7'h3F, 7'h4F, ZB, 4'b0000);

    // load coinciding with the tick that selects digit 1
    load_word(16'h5432, 4'b0000);
    while (cur != 0) next_tick();
    repeat (3) @(posedge clk);
    #1;
    bcd_in = 16'h1111; dp_in = 4'b1111; load = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
    cur = 1;
    chk("coll_an", an, 4'b0010);
    chk("coll_seg_old", seg, 7'h4F);
    chk("coll_dp_old", dp, 1'b0);
    next_tick();
    chk("coll_seg_d2_new", seg, 7'h06);
    chk("coll_dp_d2_new", dp, 1'b1);
    scan_frame("coll_next", 7'h06, 7'h06, 7'h06, 7'h06, 4'b1111);

    // mid-scan reset while digit 3 is lit with dp set
    chk("pre_rst_an", an, 4'b1000);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_an", an, 4'b0001);
    chk("mid_rst_seg", seg, 7'h3F);
    chk("mid_rst_dp", dp, 1'b0);
    chk("mid_rst_frame", frame, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_an_e%0d", e), an, (e < 4) ? 4'b0001 : 4'b0010);
      chk($sformatf("post_rst_seg_e%0d", e), seg, (e < 4) ? 7'h3F : ZB);
      chk($sformatf("post_rst_dp_e%0d", e), dp, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seg_scan.md
# bcd_seg_scan

Multiplexed seven-segment display driver that consumes packed BCD digits, such as the outputs of chained decade counters, and drives a common-cathode multi-digit display. It latches a digit word on a load strobe and scans one digit at a time at a programmable rate. For each selected digit it decodes the BCD to segments and drives the matching digit enable. It sits between the counting datapath and the board display pins.

## Interface
- NDIG, 4: number of digits; legal range 2..8.
- SCAN_DIV, 50000: clk cycles each digit stays selected; must be >= 1.
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  when high at a rising edge, capture bcd_in/dp_in into the shadow register.
- bcd_in  in  4*NDIG  packed BCD; digit i = bcd_in[4i+3:4i]; digit 0 is least significant.
- dp_in  in  NDIG  decimal point per digit; bit i belongs to digit i.
- seg  out  7  segments, active-high; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point of the selected digit, active-high.
- an  out  NDIG  digit enable, one-hot, active-high; an[i] selects digit i.
- frame  out  1  one-cycle pulse when the scan wraps back to digit 0.

## Operation
- Shadow register: holds NDIG BCD digits and NDIG dp bits. It is written only on load. Reset value is all zero.
- Prescaler: counts 0..SCAN_DIV-1 and wraps. A tick occurs in the cycle where the count equals SCAN_DIV-1.
- Digit index: advances 0→1→…→NDIG-1→0, one step per tick.
- seg, an, dp and frame are registered. They update only on a tick, from the next index and the current shadow.
- Decode (segment hex, g..a): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
- Invalid codes 10..15 display a dash (seg=40).
- dp = shadow dp bit of the selected digit.
- an is always exactly one-hot. It is never all-zero after reset.
- frame = 1 for exactly the cycle in which an becomes digit 0 because of a wrap. It is 0 at all other times.

## Timing
- Reset (asynchronous): prescaler=0, index=0, shadow=0, an=1 (digit 0), seg=3F, dp=0, frame=0.
  - Reset asserted mid-scan takes effect immediately, without waiting for a clk edge.
- After rst deasserts, the first tick occurs on the SCAN_DIV-th rising edge. That edge sets an=2 (digit 1).
- Load latency: shadow updates at the load edge. The new value reaches the outputs at the next tick that selects each digit, and no earlier.
- Load and tick at the same edge: outputs use the pre-load shadow. The new value is shown from the following tick.
- load held high: the shadow is recaptured every cycle. The last captured value wins.
- Full frame period = NDIG*SCAN_DIV cycles. frame pulses once per period.
- SCAN_DIV=1: a tick occurs every cycle, an rotates every cycle, and frame pulses every NDIG cycles.
- Wrap: at the tick where index=NDIG-1, index goes to 0, an=1 and frame=1.

## Configuration
- Macro: BCD_SEG_SCAN_LZB_EN (leading-zero blanking).
- Defined:
  - Digit i (i >= 1) is blanked (seg=00) when shadow digits i..NDIG-1 are all zero.
  - Digit 0 is never blanked.
  - dp and an are unaffected by blanking.
  - Invalid codes count as non-zero.
- Undefined: every digit is always decoded. Zero digits display 3F.

## Test plan
- Reset/first ticks (NDIG=4, SCAN_DIV=4):
  - Assert rst mid-cycle → an=1, seg=3F, dp=0 and frame=0 immediately.
  - Release rst → an=2 on the 4th edge, an=4 on the 8th, an=8 on the 12th.
  - 16th edge → an=1 with frame=1 for exactly one cycle.
- Decode sweep: load bcd_in=16'h9876, scan one frame → seg 7D, 07, 7F, 6F on digits 0..3.
  - Repeat with 16'h5432 → 5B, 4F, 66, 6D. Repeat with 16'h0010 (LZB off) → digit 1=06, digits 0/2/3=3F.
- Invalid/dp: load bcd_in=16'hFA00, dp_in=4'b0101 → digits 2/3 seg=40. dp=1 while an=1 or an=4, else 0.
- Load/tick collision: assert load with 16'h1111 on the same edge as the tick selecting digit 1 → that digit shows the old value. It shows 06 from the next frame.
- LZB_EN defined, load 16'h0070 → digit 0=3F, digit 1=07, digits 2/3 seg=00 with an still cycling.
  - Load 16'h0000 → only digit 0 lit (3F).
- SCAN_DIV=1, NDIG=2 → an toggles 1,2,1,2 every cycle. frame=1 on every cycle where an becomes 1.
